hazard_unit: RTL

//  Hazard/forwarding controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
//  - Keeps its own scoreboard of the EX, MEM and WB slots.
//  - Generates stall, flush and bubble controls, plus EX-stage operand-forwarding selects.
//  - Generalises the single-cycle datapath: parametrised register-address width, data-memory wait handshake.

---
 rtl/hazard_pkg.sv | 31 +++
 rtl/hazard_slot.sv | 37 +++
 rtl/hazard_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// Register indices are carried in slots at SLOT_AW bits so the slot layout
// stays fixed while hazard_unit's REG_AW parameter may be anything up to it.
package hazard_pkg;

    localparam int SLOT_AW = 8;

    localparam logic [SLOT_AW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic               valid;
        logic [SLOT_AW-1:0] rd;
        logic               regwrite;
        logic               is_load;
        logic [SLOT_AW-1:0] rs1;
        logic [SLOT_AW-1:0] rs2;
    } slot_t;

    // A slot produces register r when it is a real, writing instruction
    // targeting r; x0 never counts as a produced value.
    function automatic logic slot_hit(input slot_t s, input logic [SLOT_AW-1:0] r);
        return s.valid & s.regwrite & (s.rd == r) & (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_slot.sv
// One pipeline scoreboard slot: holds, clears to a NOP, or captures its input.
module hazard_slot
    import hazard_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  hold,
    input  logic  clear,
    input  slot_t slot_in,
    output slot_t slot_out
);

    slot_t slot_d;
    slot_t slot_q;

    // Next-state select: hold wins over clear, clear wins over capture.
    always_comb begin
        slot_d = slot_in;
        if (hold) begin
            slot_d = slot_q;
        end else if (clear) begin
            slot_d = '0;
        end
    end

    // Slot register; reset leaves the slot empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_out = slot_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline.
// Tracks EX/MEM/WB in three hazard_slot instances and decodes stall, flush,
// bubble, freeze and EX operand-forwarding selects combinationally.
// Build option: define HAZARD_FWD_EN to enable forwarding; without it the
// forwarding selects stay at FWD_REG and any RAW against EX or MEM stalls.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int FWD_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_is_load,
    input  logic              ex_branch_taken,
    input  logic              mem_ready,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              flush_ifid,
    output logic              bubble_ex,
    output logic              freeze,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b
);

    slot_t    id_slot;
    slot_t    ex_s;
    slot_t    mem_s;
    slot_t    wb_s;
    logic     mem_wait;
    logic     data_hazard;
    fwd_sel_t fwd_a_sel;
    fwd_sel_t fwd_b_sel;
    logic     unused_slot_bits;

    // Newest producer wins; a load in MEM has no data yet so it cannot forward.
    function automatic fwd_sel_t fwd_pick(input logic [SLOT_AW-1:0] r,
                                          input slot_t mem, input slot_t wb);
        if (slot_hit(mem, r) && !mem.is_load) begin
            return FWD_MEM;
        end else if (slot_hit(wb, r)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

    // Pack the decoded ID instruction into the slot layout for EX capture.
    always_comb begin
        id_slot          = '0;
        id_slot.valid    = id_valid;
        id_slot.rd       = SLOT_AW'(id_rd);
        id_slot.regwrite = id_regwrite;
        id_slot.is_load  = id_is_load;
        id_slot.rs1      = SLOT_AW'(id_rs1);
        id_slot.rs2      = SLOT_AW'(id_rs2);
    end

    // Detect the stall-worthy data hazard for the instruction sitting in ID.
    always_comb begin
        logic raw_ex;
        raw_ex = id_valid & ((id_use_rs1 & slot_hit(ex_s, id_slot.rs1)) |
                             (id_use_rs2 & slot_hit(ex_s, id_slot.rs2)));
`ifdef HAZARD_FWD_EN
        data_hazard = ex_s.is_load & raw_ex;
`else
        data_hazard = raw_ex |
                      (id_valid & ((id_use_rs1 & slot_hit(mem_s, id_slot.rs1)) |
                                   (id_use_rs2 & slot_hit(mem_s, id_slot.rs2))));
`endif
    end

    assign mem_wait = mem_s.valid & mem_s.is_load & ~mem_ready;

    // Control decode in priority order: reset, memory wait, taken branch, data hazard.
    always_comb begin
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        flush_ifid = 1'b0;
        bubble_ex  = 1'b0;
        freeze     = 1'b0;
        fwd_a_sel  = FWD_REG;
        fwd_b_sel  = FWD_REG;
        if (!rst) begin
            if (mem_wait) begin
                freeze     = 1'b1;
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
            end else if (ex_branch_taken) begin
                flush_ifid = 1'b1;
                bubble_ex  = 1'b1;
            end else if (data_hazard) begin
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
                bubble_ex  = 1'b1;
            end
`ifdef HAZARD_FWD_EN
            if (ex_s.valid) begin
                fwd_a_sel = fwd_pick(ex_s.rs1, mem_s, wb_s);
                fwd_b_sel = fwd_pick(ex_s.rs2, mem_s, wb_s);
            end
`endif
        end
    end

    assign fwd_a = FWD_W'(fwd_a_sel);
    assign fwd_b = FWD_W'(fwd_b_sel);

    // Some slot fields are only consumed in one build flavour.
    assign unused_slot_bits = ^{ex_s, mem_s, wb_s};

    hazard_slot u_ex (
        .clk      (clk),
        .rst      (rst),
        .hold     (freeze),
        .clear    (bubble_ex),
        .slot_in  (id_slot),
        .slot_out (ex_s)
    );

    hazard_slot u_mem (
        .clk      (clk),
        .rst      (rst),
        .hold     (freeze),
        .clear    (1'b0),
        .slot_in  (ex_s),
        .slot_out (mem_s)
    );

    hazard_slot u_wb (
        .clk      (clk),
        .rst      (rst),
        .hold     (freeze),
        .clear    (1'b0),
        .slot_in  (mem_s),
        .slot_out (wb_s)
    );

endmodule
